time_set_entry: RTL and testbench

- Reverse path of the clock display chain: accepts a user-entered sequence of six BCD digits (HH MM SS) and converts them to binary hr/min/sec.
- Issues a one-cycle load strobe so the timekeeping counters can preload the new time.
- Sits between the keypad/button debouncer and the hr/min/sec counters.
- Exposes the staged digits and cursor position so the display path can show and blink the digit being edited.

---
 rtl/time_set_entry.sv | 145 ++++++++++++++
 tb/tb_time_set_entry.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_entry.sv
// rtl/time_set_entry.sv - six-digit BCD HH:MM:SS entry FSM producing binary hr/min/sec and a load strobe
// Optional backspace input enabled by defining TIME_SET_BACKSPACE_EN.
module time_set_entry #(
  parameter int TIMEOUT_CYCLES = 500000000,
  parameter int TO_W           = 29
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cancel,
`ifdef TIME_SET_BACKSPACE_EN
  input  logic        back,
`endif
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  output logic        editing,
  output logic [2:0]  cursor,
  output logic [23:0] stg_digits,
  output logic        digit_err,
  output logic [4:0]  hr_set,
  output logic [5:0]  min_set,
  output logic [5:0]  sec_set,
  output logic        load
);

  // Digit states share their encoding with the cursor value they display.
  typedef enum logic [2:0] {
    H_T    = 3'd0,
    H_O    = 3'd1,
    M_T    = 3'd2,
    M_O    = 3'd3,
    S_T    = 3'd4,
    S_O    = 3'd5,
    COMMIT = 3'd6,
    IDLE   = 3'd7
  } state_t;

  state_t          state, state_nx;
  logic [3:0]      slot [6];
  logic [TO_W-1:0] to_cnt;
  logic            accept, reject, restart, step_back, edit_nx;
  logic [2:0]      idx, prev_idx;

  function automatic logic digit_ok(input logic [2:0] pos, input logic [3:0] d,
                                    input logic [3:0] h_t);
    logic ok;
    ok = 1'b1;
    if (d > 4'd9) begin
      ok = 1'b0;
    end else begin
      case (pos)
        3'd0:       ok = (d <= 4'd2);
        3'd1:       ok = (h_t == 4'd2) ? (d <= 4'd3) : 1'b1;
        3'd2, 3'd4: ok = (d <= 4'd5);
        default:    ok = 1'b1;
      endcase
    end
    return ok;
  endfunction

  function automatic logic [6:0] bcd_to_bin(input logic [3:0] t, input logic [3:0] o);
    logic [6:0] t7;
    t7 = {3'b000, t};
    return (t7 << 3) + (t7 << 1) + {3'b000, o};
  endfunction

  assign idx        = state;
  assign prev_idx   = idx - 3'd1;
  assign stg_digits = {slot[0], slot[1], slot[2], slot[3], slot[4], slot[5]};
  assign edit_nx    = (state_nx != IDLE) && (state_nx != COMMIT);

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    reject    = 1'b0;
    restart   = 1'b0;
    step_back = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          restart  = 1'b1;
          state_nx = H_T;
        end
      end
      COMMIT: state_nx = IDLE;
      default: begin
        if (cancel) begin
          state_nx = IDLE;
        end else if (start) begin
          restart  = 1'b1;
          state_nx = H_T;
`ifdef TIME_SET_BACKSPACE_EN
        end else if (back && (state != H_T)) begin
          step_back = 1'b1;
          state_nx  = state_t'(prev_idx);
`endif
        end else if (digit_valid) begin
          if (digit_ok(idx, digit, slot[0])) begin
            accept   = 1'b1;
            state_nx = (state == S_O) ? COMMIT : state_t'(idx + 3'd1);
          end else begin
            reject = 1'b1;
          end
        end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_nx = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      editing   <= 1'b0;
      cursor    <= 3'd7;
      digit_err <= 1'b0;
      load      <= 1'b0;
      hr_set    <= 5'd0;
      min_set   <= 6'd0;
      sec_set   <= 6'd0;
      to_cnt    <= '0;
      for (int i = 0; i < 6; i++) slot[i] <= 4'd0;
    end else begin
      state     <= state_nx;
      editing   <= edit_nx;
      cursor    <= edit_nx ? 3'(state_nx) : 3'd7;
      digit_err <= reject;
      load      <= (state == COMMIT);
      if (state == COMMIT) begin
        hr_set  <= 5'(bcd_to_bin(slot[0], slot[1]));
        min_set <= 6'(bcd_to_bin(slot[2], slot[3]));
        sec_set <= 6'(bcd_to_bin(slot[4], slot[5]));
      end
      if (restart) begin
        for (int i = 0; i < 6; i++) slot[i] <= 4'd0;
      end
      if (accept) slot[idx] <= digit;
      if (step_back) slot[prev_idx] <= 4'd0;
      // Any digit activity or leaving edit mode restarts the inactivity window.
      if (restart || accept || reject || step_back || !edit_nx) to_cnt <= '0;
      else to_cnt <= to_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_time_set_entry.sv
// tb/tb_time_set_entry.sv - scoreboard bench for time_set_entry with a digit-list reference model
module tb_time_set_entry;
  logic        clk = 1'b0;
  logic        rst, start, cancel, back, digit_valid;
  logic [3:0]  digit;
  logic        editing, digit_err, load;
  logic [2:0]  cursor;
  logic [23:0] stg_digits;
  logic [4:0]  hr_set;
  logic [5:0]  min_set, sec_set;

  always #5 clk = ~clk;

  time_set_entry #(.TIMEOUT_CYCLES(20), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .cancel(cancel),
`ifdef TIME_SET_BACKSPACE_EN
    .back(back),
`endif
    .digit_valid(digit_valid), .digit(digit), .editing(editing), .cursor(cursor),
    .stg_digits(stg_digits), .digit_err(digit_err), .hr_set(hr_set),
    .min_set(min_set), .sec_set(sec_set), .load(load)
  );

  typedef struct { int hr; int mn; int sc; logic [23:0] stg; } load_t;
  load_t load_q[$];
  int    err_q[$];

  int checks = 0;
  int errors = 0;

  // Model: mode 0=idle 1=edit 2=commit; pos = number of digits entered so far.
  int mode = 0;
  int pos = 0;
  int digs[6];
  int last_hr = 0, last_mn = 0, last_sc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] stg_model();
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r = {r[19:0], 4'(digs[i])};
    return r;
  endfunction

  function automatic bit legal(int p, int d);
    if (d > 9) return 0;
    case (p)
      0: return d <= 2;
      1: return digs[0] * 10 + d <= 23;
      2, 4: return d <= 5;
      default: return 1;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 6; i++) digs[i] = 0;
    pos = 0;
  endtask

  task automatic step(input bit s, input bit c, input bit b, input bit dv, input int d);
    load_t e;
    @(negedge clk);
    start = s; cancel = c; back = b; digit_valid = dv; digit = 4'(d);
    if (mode == 1) begin
      if (c) mode = 0;
      else if (s) model_clear();
`ifdef TIME_SET_BACKSPACE_EN
      else if (b && pos > 0) begin pos--; digs[pos] = 0; end
`endif
      else if (dv) begin
        if (legal(pos, d)) begin
          digs[pos] = d;
          pos++;
          if (pos == 6) begin
            e.hr = digs[0] * 10 + digs[1];
            e.mn = digs[2] * 10 + digs[3];
            e.sc = digs[4] * 10 + digs[5];
            e.stg = stg_model();
            load_q.push_back(e);
            last_hr = e.hr; last_mn = e.mn; last_sc = e.sc;
            mode = 2;
          end
        end else begin
          err_q.push_back(pos);
        end
      end
    end else if (mode == 0 && s) begin
      mode = 1;
      model_clear();
    end
    @(negedge clk);
    start = 0; cancel = 0; back = 0; digit_valid = 0;
    chk("cursor", cursor, (mode == 1) ? pos : 7);
    chk("editing", editing, mode == 1);
    chk("stg_digits", stg_digits, stg_model());
    if (mode == 2) mode = 0;
  endtask

  task automatic dig(input int d);
    step(0, 0, 0, 1, d);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_editing"}, editing, 0);
    chk({tag, "_cursor"}, cursor, 7);
    chk({tag, "_stg"}, stg_digits, 0);
    chk({tag, "_err"}, digit_err, 0);
    chk({tag, "_load"}, load, 0);
    chk({tag, "_hr"}, hr_set, 0);
    chk({tag, "_min"}, min_set, 0);
    chk({tag, "_sec"}, sec_set, 0);
  endtask

  // Monitor: pops expectations whenever the DUT presents load or digit_err.
  initial begin
    load_t e;
    int    c;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (load === 1'b1) begin
          if (load_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL load_unexpected: actual=1 required=0");
          end else begin
            e = load_q.pop_front();
            chk("hr_set", hr_set, e.hr);
            chk("min_set", min_set, e.mn);
            chk("sec_set", sec_set, e.sc);
            chk("load_stg", stg_digits, e.stg);
            chk("load_editing", editing, 0);
          end
        end
        if (digit_err === 1'b1) begin
          if (err_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL digit_err_unexpected: actual=1 required=0");
          end else begin
            c = err_q.pop_front();
            chk("err_cursor", cursor, c);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r;
    rst = 1; start = 0; cancel = 0; back = 0; digit_valid = 0; digit = 0;
    model_clear();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 0;
    @(negedge clk);

    step(1, 0, 0, 0, 0);
    foreach (digs[i]) dig(i + 1);
    repeat (3) @(negedge clk);
    chk("t1_hold_hr", hr_set, 12);

    step(1, 0, 0, 0, 0);
    dig(2); dig(4); dig(3); dig(5); dig(9); dig(5); dig(9);
    repeat (3) @(negedge clk);

    step(1, 0, 0, 0, 0);
    dig(0); dig(7); dig(6); dig(10); dig(15); dig(0); dig(0); dig(0); dig(0);
    repeat (3) @(negedge clk);

    step(1, 0, 0, 0, 0);
    dig(1); dig(1);
    step(0, 1, 0, 1, 5);
    chk("cancel_hr", hr_set, last_hr);
    chk("cancel_min", min_set, last_mn);
    chk("cancel_sec", sec_set, last_sc);
    step(1, 0, 0, 0, 0);
    dig(3);
    step(0, 1, 0, 0, 0);

`ifdef TIME_SET_BACKSPACE_EN
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    dig(1); dig(5); step(0, 0, 1, 0, 0); dig(4); dig(0); dig(0); dig(0); dig(0);
    repeat (3) @(negedge clk);
    chk("back_hr", hr_set, 14);
`endif

    // Inactivity abort: 20 idle cycles after the last digit.
    step(1, 0, 0, 0, 0);
    dig(1);
    n = 0;
    while (editing === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    mode = 0;
    chk("timeout_cycles", n, 20);
    chk("timeout_cursor", cursor, 7);

    for (int s = 0; s < 40; s++) begin
      step(1, 0, 0, 0, 0);
      for (int k = 0; k < 25 && mode == 1; k++) begin
        r = $urandom_range(0, 99);
        if (r < 4) step(0, 1, 0, $urandom_range(0, 1), $urandom_range(0, 9));
        else if (r < 7) step(1, 0, 0, 0, 0);
`ifdef TIME_SET_BACKSPACE_EN
        else if (r < 13) step(0, 0, 1, 0, 0);
`endif
        else if (r < 80) dig($urandom_range(0, 9));
        else dig($urandom_range(0, 15));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      if (mode == 1) step(0, 1, 0, 0, 0);
      repeat (2) @(negedge clk);
    end

    // Reset in mid-entry after a committed time.
    step(1, 0, 0, 0, 0);
    foreach (digs[i]) dig(9 - i * 2 > 5 ? 1 : 2);
    repeat (3) @(negedge clk);
    step(1, 0, 0, 0, 0);
    dig(1); dig(2);
    rst = 1;
    @(negedge clk);
    check_reset_values("midrst");
    rst = 0;
    mode = 0; model_clear();
    last_hr = 0; last_mn = 0; last_sc = 0;

    repeat (5) @(negedge clk);
    chk("load_q_empty", load_q.size(), 0);
    chk("err_q_empty", err_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
